warp_fetch_scheduler: RTL and testbench
=======================================

WARP_FETCH_SCHEDULER -- requirements
Module: warp_fetch_scheduler

Interface
REQ-001 SHALL have parameter PC_WIDTH, default 8, byte-address width of each warp program counter.
REQ-002 SHALL have parameter INST_WIDTH, default 16, instruction word width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port start, input, 1, kernel launch pulse.
REQ-006 SHALL have port start_pc, input, PC_WIDTH, initial PC loaded into every enabled warp.
REQ-007 SHALL have port warp_mask, input, 4, warps enabled at launch (bit i = warp i).
REQ-008 SHALL have port imem_addr, output, PC_WIDTH, address to instruction memory (combinational-read ROM, word = addr[PC_WIDTH-1:1]).
REQ-009 SHALL have port imem_inst, input, INST_WIDTH, instruction returned same cycle.
REQ-010 SHALL have ports inst_valid (output, 1), inst (output, INST_WIDTH), inst_warp (output, 2), inst_pc (output, PC_WIDTH): registered issue slot to decode.
REQ-011 SHALL have port inst_ready, input, 1, decode accepts slot when inst_valid and inst_ready both high.
REQ-012 SHALL have ports mem_ack (input, 1) and ack_warp (input, 2): LD/ST completion for warp ack_warp.
REQ-013 SHALL have ports busy (output, 1, high in RUN) and done (output, 1, one-cycle pulse at kernel end).

Function
REQ-014 SHALL implement FSM IDLE -> RUN on start with warp_mask != 0; RUN -> DONE when no warp active and inst_valid low; DONE -> IDLE unconditionally after one cycle.
REQ-015 SHALL ignore start in RUN and DONE, and ignore start with warp_mask == 0 in IDLE.
REQ-016 SHALL on accepted start load pc[i] = start_pc, active[i] = warp_mask[i], blocked[i] = 0 for all four warps.
REQ-017 SHALL treat warp i as eligible when active[i] and not blocked[i].
REQ-018 SHALL fetch in a RUN cycle only if an eligible warp exists and slot is free (inst_valid low, or inst_valid and inst_ready high).
REQ-019 SHALL select the fetched warp round-robin: search order starts at (last_grant+1) mod 4; last_grant updates to the fetched warp.
REQ-020 SHALL drive imem_addr = pc[selected] in a fetch cycle and 0 otherwise.
REQ-021 SHALL in a fetch cycle advance pc[selected] by 2, wrapping modulo 2^PC_WIDTH (0xFE -> 0x00).
REQ-022 SHALL treat opcode imem_inst[15:12] == 4'b0000 as HALT: clear active[selected], do not load slot (inst_valid low next cycle unless otherwise loaded).
REQ-023 SHALL for non-HALT opcodes load inst, inst_warp, inst_pc (pre-increment PC) and set inst_valid next cycle: fetch-to-valid latency one cycle.
REQ-024 SHALL set blocked[selected] when the fetched opcode is 4'b0001 (LD) or 4'b0010 (ST).
REQ-025 SHALL clear blocked[ack_warp] on mem_ack; mem_ack for a non-blocked warp is ignored; mem_ack in IDLE/DONE is ignored.
REQ-026 SHALL keep inst, inst_warp, inst_pc stable while inst_valid high and inst_ready low.
REQ-027 SHALL clear inst_valid on handshake when no new fetch occurs in that cycle; back-to-back issue allowed (one instruction per cycle).
REQ-028 SHALL NOT enter DONE while any warp is blocked (blocked warp remains active).
REQ-029 SHALL hold busy high exactly in RUN; done high exactly in DONE.

Reset
REQ-030 SHALL on rst_n low asynchronously force state IDLE, pc[*]=0, active=0, blocked=0, last_grant=3, inst_valid=0, inst=0, inst_warp=0, inst_pc=0, busy=0, done=0, regardless of operation in progress.
REQ-031 SHALL resume only on a new start after rst_n deasserts.

Verification
REQ-032 SHALL verify: start, start_pc=0x10, mask=4'b1111, ROM ALU ops, inst_ready=1 -> issued (warp,pc) = (0,0x10),(1,0x10),(2,0x10),(3,0x10),(0,0x12) on consecutive cycles.
REQ-033 SHALL verify: mask=4'b0101, warp 0 fetches LD at 0x10 -> warp 0 skipped (only warp 2 issues) until mem_ack ack_warp=0, then warp 0 issues 0x12.
REQ-034 SHALL verify: inst_ready held low 3 cycles with inst_valid high -> outputs stable, imem_addr=0, no PC advances.
REQ-035 SHALL verify: single warp mask=4'b0001, HALT at 0x14 -> instructions 0x10, 0x12 issued, no issue at 0x14, done pulses one cycle after last handshake, busy falls.
REQ-036 SHALL verify: start_pc=0xFE, mask=4'b0001 -> second fetch at imem_addr=0x00.
REQ-037 SHALL verify: rst_n pulsed low mid-RUN with warp blocked -> all outputs reset values immediately; subsequent mem_ack ignored; new start launches cleanly.

Source files
------------

// File: rtl/warp_fetch_scheduler.sv
// Four-warp instruction fetch scheduler: round-robin fetch of eligible warps into
// a single registered issue slot, with LD/ST blocking and HALT retirement.
module warp_fetch_scheduler #(
  parameter int PC_WIDTH   = 8,
  parameter int INST_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [PC_WIDTH-1:0]   start_pc,
  input  logic [3:0]            warp_mask,
  output logic [PC_WIDTH-1:0]   imem_addr,
  input  logic [INST_WIDTH-1:0] imem_inst,
  output logic                  inst_valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [1:0]            inst_warp,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  inst_ready,
  input  logic                  mem_ack,
  input  logic [1:0]            ack_warp,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Lowest priority goes to the last granted warp; search starts one past it.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] pick;
    logic [1:0] idx;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) begin
        pick = idx;
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  state_t                state_r, state_s;
  logic [PC_WIDTH-1:0]   pc_r [4];
  logic [PC_WIDTH-1:0]   pc_s [4];
  logic [3:0]            active_r, active_s;
  logic [3:0]            blocked_r, blocked_s;
  logic [1:0]            last_grant_r, last_grant_s;
  logic                  inst_valid_r, inst_valid_s;
  logic [INST_WIDTH-1:0] inst_r, inst_s;
  logic [1:0]            inst_warp_r, inst_warp_s;
  logic [PC_WIDTH-1:0]   inst_pc_r, inst_pc_s;
  logic                  busy_r, done_r;

  logic [3:0] eligible_s;
  logic       slot_free_s;
  logic       fetch_s;
  logic [1:0] sel_s;
  logic [3:0] opcode_s;
  logic       is_halt_s;
  logic       is_mem_s;

  assign eligible_s  = active_r & ~blocked_r;
  assign slot_free_s = ~inst_valid_r | inst_ready;
  assign fetch_s     = (state_r == ST_RUN) && (eligible_s != 4'b0000) && slot_free_s;
  assign sel_s       = rr_pick(eligible_s, last_grant_r);
  assign imem_addr   = fetch_s ? pc_r[sel_s] : {PC_WIDTH{1'b0}};
  assign opcode_s    = imem_inst[15:12];
  assign is_halt_s   = (opcode_s == 4'b0000);
  assign is_mem_s    = (opcode_s == 4'b0001) || (opcode_s == 4'b0010);

  assign inst_valid = inst_valid_r;
  assign inst       = inst_r;
  assign inst_warp  = inst_warp_r;
  assign inst_pc    = inst_pc_r;
  assign busy       = busy_r;
  assign done       = done_r;

  // Kernel state machine: next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start && (warp_mask != 4'b0000)) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if ((active_r == 4'b0000) && !inst_valid_r) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Warp context and issue-slot next values; a fetch overrides a handshake clear.
  always_comb begin
    pc_s         = pc_r;
    active_s     = active_r;
    blocked_s    = blocked_r;
    last_grant_s = last_grant_r;
    inst_valid_s = inst_valid_r;
    inst_s       = inst_r;
    inst_warp_s  = inst_warp_r;
    inst_pc_s    = inst_pc_r;
    if ((state_r == ST_IDLE) && start && (warp_mask != 4'b0000)) begin
      for (int i = 0; i < 4; i++) begin
        pc_s[i] = start_pc;
      end
      active_s  = warp_mask;
      blocked_s = 4'b0000;
    end else if (state_r == ST_RUN) begin
      if (mem_ack) begin
        blocked_s[ack_warp] = 1'b0;
      end else begin
        blocked_s = blocked_r;
      end
      if (inst_valid_r && inst_ready) begin
        inst_valid_s = 1'b0;
      end else begin
        inst_valid_s = inst_valid_r;
      end
      if (fetch_s) begin
        pc_s[sel_s]  = pc_r[sel_s] + PC_WIDTH'(2);
        last_grant_s = sel_s;
        if (is_halt_s) begin
          active_s[sel_s] = 1'b0;
        end else begin
          inst_valid_s = 1'b1;
          inst_s       = imem_inst;
          inst_warp_s  = sel_s;
          inst_pc_s    = pc_r[sel_s];
          if (is_mem_s) begin
            blocked_s[sel_s] = 1'b1;
          end else begin
            blocked_s[sel_s] = blocked_s[sel_s];
          end
        end
      end else begin
        last_grant_s = last_grant_r;
      end
    end else begin
      active_s = active_r;
    end
  end

  // State, warp context and issue slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      for (int i = 0; i < 4; i++) begin
        pc_r[i] <= {PC_WIDTH{1'b0}};
      end
      active_r     <= 4'b0000;
      blocked_r    <= 4'b0000;
      last_grant_r <= 2'd3;
      inst_valid_r <= 1'b0;
      inst_r       <= {INST_WIDTH{1'b0}};
      inst_warp_r  <= 2'd0;
      inst_pc_r    <= {PC_WIDTH{1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      for (int i = 0; i < 4; i++) begin
        pc_r[i] <= pc_s[i];
      end
      active_r     <= active_s;
      blocked_r    <= blocked_s;
      last_grant_r <= last_grant_s;
      inst_valid_r <= inst_valid_s;
      inst_r       <= inst_s;
      inst_warp_r  <= inst_warp_s;
      inst_pc_r    <= inst_pc_s;
      busy_r       <= (state_s == ST_RUN);
      done_r       <= (state_s == ST_DONE);
    end
  end

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Self-checking bench for warp_fetch_scheduler: directed vector table, hand-written
// corner sequences and randomized kernels against a cycle-level reference model.
module tb_warp_fetch_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  start_pc;
  logic [3:0]  warp_mask;
  logic [7:0]  imem_addr;
  logic [15:0] imem_inst;
  logic        inst_valid;
  logic [15:0] inst;
  logic [1:0]  inst_warp;
  logic [7:0]  inst_pc;
  logic        inst_ready;
  logic        mem_ack;
  logic [1:0]  ack_warp;
  logic        busy;
  logic        done;

  logic [15:0] rom [128];

  warp_fetch_scheduler #(.PC_WIDTH(8), .INST_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_pc(start_pc), .warp_mask(warp_mask),
    .imem_addr(imem_addr), .imem_inst(imem_inst), .inst_valid(inst_valid), .inst(inst),
    .inst_warp(inst_warp), .inst_pc(inst_pc), .inst_ready(inst_ready), .mem_ack(mem_ack),
    .ack_warp(ack_warp), .busy(busy), .done(done)
  );

  assign imem_inst = rom[imem_addr[7:1]];
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 run, 2 done
  int          m_state;
  logic [7:0]  m_pc [4];
  logic [3:0]  m_active, m_blocked;
  int          m_lg;
  logic        m_valid;
  logic [15:0] m_inst;
  logic [1:0]  m_warp;
  logic [7:0]  m_ipc;

  typedef struct {
    logic       start;
    logic [7:0] spc;
    logic [3:0] mask;
    logic       ready;
    logic       ev;
    logic [1:0] ew;
    logic [7:0] epc;
    logic [7:0] eaddr;
    logic       ebusy;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    for (int i = 0; i < 4; i++) m_pc[i] = 8'h00;
    m_active  = 4'b0000;
    m_blocked = 4'b0000;
    m_lg      = 3;
    m_valid   = 1'b0;
    m_inst    = 16'h0000;
    m_warp    = 2'd0;
    m_ipc     = 8'h00;
  endtask

  // Called just after a rising edge; compares mid-cycle, advances the model at the next edge.
  task automatic tick();
    int          sel;
    int          w;
    bit          fetch;
    logic [7:0]  addr;
    logic [15:0] word;
    logic [3:0]  op;
    int          nstate;
    #3;
    fetch = 1'b0;
    sel   = 0;
    addr  = 8'h00;
    if (m_state == 1 && (!m_valid || inst_ready)) begin
      for (int k = 1; k <= 4; k++) begin
        w = (m_lg + k) % 4;
        if (!fetch && m_active[w] && !m_blocked[w]) begin
          fetch = 1'b1;
          sel   = w;
        end
      end
    end
    if (fetch) addr = m_pc[sel];
    chk("imem_addr", imem_addr, addr);
    chk("inst_valid", inst_valid, m_valid);
    chk("inst", inst, m_inst);
    chk("inst_warp", inst_warp, m_warp);
    chk("inst_pc", inst_pc, m_ipc);
    chk("busy", busy, (m_state == 1));
    chk("done", done, (m_state == 2));
    word   = rom[addr[7:1]];
    op     = word[15:12];
    nstate = m_state;
    case (m_state)
      0: begin
        if (start && warp_mask != 4'b0000) begin
          nstate = 1;
          for (int i = 0; i < 4; i++) m_pc[i] = start_pc;
          m_active  = warp_mask;
          m_blocked = 4'b0000;
        end
      end
      1: begin
        if (m_active == 4'b0000 && !m_valid) nstate = 2;
        if (mem_ack) m_blocked[ack_warp] = 1'b0;
        if (m_valid && inst_ready) m_valid = 1'b0;
        if (fetch) begin
          m_pc[sel] = m_pc[sel] + 8'd2;
          m_lg = sel;
          if (op == 4'd0) begin
            m_active[sel] = 1'b0;
          end else begin
            m_valid = 1'b1;
            m_inst  = word;
            m_warp  = sel[1:0];
            m_ipc   = addr;
            if (op == 4'd1 || op == 4'd2) m_blocked[sel] = 1'b1;
          end
        end
      end
      default: nstate = 0;
    endcase
    @(posedge clk);
    m_state = nstate;
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; mem_ack = 1'b0; ack_warp = 2'd0; inst_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic fill_alu();
    for (int i = 0; i < 128; i++) rom[i] = 16'h3000 + 16'(i);
  endtask

  task automatic launch(input logic [7:0] pc, input logic [3:0] mask);
    start = 1'b1; start_pc = pc; warp_mask = mask;
    tick();
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start_pc = 8'h00; warp_mask = 4'b0000;
    inst_ready = 1'b1; mem_ack = 1'b0; ack_warp = 2'd0;
    fill_alu();
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    chk("reset_valid", inst_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst_n = 1'b1;

    // Four warps, all ALU: round-robin issue starting at warp 0
    vecs[0] = '{1'b1, 8'h10, 4'b1111, 1'b1, 1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 8'h10, 4'b1111, 1'b1, 1'b0, 2'd0, 8'h00, 8'h10, 1'b1};
    vecs[2] = '{1'b0, 8'h10, 4'b1111, 1'b1, 1'b1, 2'd0, 8'h10, 8'h10, 1'b1};
    vecs[3] = '{1'b0, 8'h10, 4'b1111, 1'b1, 1'b1, 2'd1, 8'h10, 8'h10, 1'b1};
    vecs[4] = '{1'b0, 8'h10, 4'b1111, 1'b1, 1'b1, 2'd2, 8'h10, 8'h10, 1'b1};
    vecs[5] = '{1'b0, 8'h10, 4'b1111, 1'b1, 1'b1, 2'd3, 8'h10, 8'h12, 1'b1};
    vecs[6] = '{1'b0, 8'h10, 4'b1111, 1'b1, 1'b1, 2'd0, 8'h12, 8'h12, 1'b1};
    for (int r = 0; r < 7; r++) begin
      start = vecs[r].start; start_pc = vecs[r].spc; warp_mask = vecs[r].mask;
      inst_ready = vecs[r].ready;
      #2;
      chk("vec_valid", inst_valid, vecs[r].ev);
      chk("vec_warp", inst_warp, vecs[r].ew);
      chk("vec_pc", inst_pc, vecs[r].epc);
      chk("vec_addr", imem_addr, vecs[r].eaddr);
      chk("vec_busy", busy, vecs[r].ebusy);
      tick();
    end

    // LD on warp 0 blocks it until its ack; warp 2 keeps issuing
    do_reset(); fill_alu(); rom[8] = 16'h1234;
    launch(8'h10, 4'b0101);
    tick();
    rom[8] = 16'h3008;
    tick();
    for (int c = 0; c < 4; c++) begin
      chk("ld_skip_valid", inst_valid, 1'b1);
      chk("ld_skip_warp", inst_warp, 2'd2);
      tick();
    end
    mem_ack = 1'b1; ack_warp = 2'd0;
    tick();
    mem_ack = 1'b0;
    tick();
    chk("ld_resume_warp", inst_warp, 2'd0);
    chk("ld_resume_pc", inst_pc, 8'h12);

    // Back-pressure: slot holds, no fetch address, no PC advance
    do_reset(); fill_alu();
    launch(8'h10, 4'b0001);
    tick();
    for (int c = 0; c < 3; c++) begin
      inst_ready = 1'b0;
      #1;
      chk("stall_addr", imem_addr, 8'h00);
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_pc", inst_pc, 8'h10);
      tick();
    end
    inst_ready = 1'b1;
    tick();
    chk("stall_next_pc", inst_pc, 8'h12);

    // HALT at 0x14 ends the kernel
    do_reset(); fill_alu(); rom[10] = 16'h0000;
    launch(8'h10, 4'b0001);
    tick(); tick();
    chk("halt_last_valid", inst_valid, 1'b1);
    chk("halt_last_pc", inst_pc, 8'h12);
    tick();
    chk("halt_no_issue", inst_valid, 1'b0);
    chk("halt_busy_run", busy, 1'b1);
    tick();
    chk("halt_done", done, 1'b1);
    chk("halt_busy_fall", busy, 1'b0);
    tick();
    chk("halt_done_pulse", done, 1'b0);

    // PC wrap from 0xFE to 0x00
    do_reset(); fill_alu();
    launch(8'hFE, 4'b0001);
    #1;
    chk("wrap_first_addr", imem_addr, 8'hFE);
    tick();
    #1;
    chk("wrap_second_addr", imem_addr, 8'h00);
    tick();

    // Reset mid-run with a blocked warp
    do_reset(); fill_alu(); rom[8] = 16'h2000;
    launch(8'h10, 4'b0001);
    tick(); tick();
    chk("rst_pre_busy", busy, 1'b1);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 16'h0000);
    chk("rst_warp", inst_warp, 2'd0);
    chk("rst_pc", inst_pc, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_addr", imem_addr, 8'h00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mem_ack = 1'b1; ack_warp = 2'd0;
    tick();
    mem_ack = 1'b0;
    chk("rst_ack_ignored", busy, 1'b0);
    rom[8] = 16'h3008;
    launch(8'h20, 4'b0001);
    tick();
    chk("relaunch_valid", inst_valid, 1'b1);
    chk("relaunch_pc", inst_pc, 8'h20);

    // Randomized kernels
    do_reset();
    for (int kern = 0; kern < 20; kern++) begin
      for (int i = 0; i < 128; i++) begin
        logic [3:0] op;
        op = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        rom[i] = {op, 12'($urandom)};
      end
      if (kern % 4 == 0) launch(8'h40, 4'b0000);
      launch({7'($urandom), 1'b0}, 4'($urandom_range(1, 15)));
      for (int c = 0; c < 3000 && m_state != 0; c++) begin
        inst_ready = ($urandom_range(0, 9) < 7);
        mem_ack    = ($urandom_range(0, 3) == 0);
        ack_warp   = 2'($urandom);
        start      = ($urandom_range(0, 15) == 0);
        start_pc   = {7'($urandom), 1'b0};
        warp_mask  = 4'($urandom);
        tick();
      end
      start = 1'b0; mem_ack = 1'b0;
      chk("kernel_end_busy", busy, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
